cxl_arbiter: RTL and testbench

CXL_ARBITER -- requirements
Module: cxl_arbiter

---
 rtl/cxl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/cxl_arbiter.sv | 113 +++++++++++
 tb/tb_cxl_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cxl_pkg.sv
// rtl/cxl_pkg.sv - shared widths and cancel record type for the cancel arbiter
//
// Purpose: field widths for client id, amount and drop counter, plus the
// packed cancel record carried through the output slot.
package cxl_pkg;

  localparam int CLIENT_W = 5;
  localparam int AMOUNT_W = 16;
  localparam int DROP_W   = 8;

  typedef struct packed {
    logic [CLIENT_W-1:0] client;
    logic [AMOUNT_W-1:0] amount;
  } cancel_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant
//
// Purpose: picks the first asserted request at or after ptr, wrapping
// around, and returns it as a one-hot grant (all zero when nothing requests).
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [PTR_W-1:0]  index that has highest priority this cycle
//   grant [N-1:0]      one-hot grant, or zero
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  int               w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Walk the requesters in priority order ptr, ptr+1, ... with wrap.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = PTR_W'(w_sum);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cxl_arbiter.sv
// rtl/cxl_arbiter.sv - round-robin cancel arbiter with one-deep output slot and duplicate suppression
//
// Purpose: merges NUM_REQ cancel requesters into a single registered output
// slot, round-robin, one cancel per cycle; optionally drops a cancel identical
// to the one most recently loaded into the slot and counts the drops.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_client/req_amount per-requester cancel, packed by index
//   req_ready                       one-hot consume strobe (combinational)
//   out_valid/out_client/out_amount registered downstream cancel
//   out_ready                       downstream accept
//   drop_cnt                        saturating count of suppressed duplicates
module cxl_arbiter
  import cxl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEDUP   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CLIENT_W-1:0]  req_client,
  input  logic [NUM_REQ*AMOUNT_W-1:0]  req_amount,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [CLIENT_W-1:0]          out_client,
  output logic [AMOUNT_W-1:0]          out_amount,
  input  logic                         out_ready,
  output logic [DROP_W-1:0]            drop_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  r_rr_ptr;
  cancel_t           r_out;
  logic              r_out_valid;
  cancel_t           r_last;
  logic              r_last_valid;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_slot_free;
  logic [NUM_REQ-1:0] w_grant;
  logic              w_any;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [PTR_W-1:0]  w_next_ptr;
  cancel_t           w_sel;
  logic              w_dup;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant)
  );

  // The slot can take a new cancel when empty or being drained this cycle.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_any       = |w_grant;
  assign req_ready   = (w_slot_free && !rst) ? w_grant : '0;

  // Decode the one-hot grant into an index and the granted cancel fields.
  always_comb begin
    w_gnt_idx = '0;
    w_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx    = PTR_W'(i);
        w_sel.client = req_client[i*CLIENT_W +: CLIENT_W];
        w_sel.amount = req_amount[i*AMOUNT_W +: AMOUNT_W];
      end
    end
  end

  assign w_next_ptr = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // r_last tracks the latest slot load, even one already accepted downstream.
  assign w_dup = (DEDUP != 0) && r_last_valid && (w_sel == r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_last       <= '0;
      r_last_valid <= 1'b0;
      r_drop_cnt   <= '0;
    end else if (w_slot_free) begin
      if (w_any) begin
        r_rr_ptr <= w_next_ptr;
        if (w_dup) begin
          // Duplicate is consumed but never issued.
          r_out_valid <= 1'b0;
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        end else begin
          r_out_valid  <= 1'b1;
          r_out        <= w_sel;
          r_last       <= w_sel;
          r_last_valid <= 1'b1;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_client = r_out.client;
  assign out_amount = r_out.amount;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_cxl_arbiter.sv
// tb/tb_cxl_arbiter.sv - scoreboard bench for cxl_arbiter against a queue-based reference model
module tb_cxl_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [19:0] req_client = '0;
  logic [63:0] req_amount = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [4:0]  out_client;
  logic [15:0] out_amount;
  logic        out_ready = 1'b0;
  logic [7:0]  drop_cnt;

  logic [3:0]  req_ready0;
  logic        out_valid0;
  logic [4:0]  out_client0;
  logic [15:0] out_amount0;
  logic [7:0]  drop_cnt0;

  always #5 clk = ~clk;

  cxl_arbiter #(.NUM_REQ(4), .DEDUP(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_client(req_client),
    .req_amount(req_amount), .req_ready(req_ready), .out_valid(out_valid),
    .out_client(out_client), .out_amount(out_amount), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  cxl_arbiter #(.NUM_REQ(4), .DEDUP(0)) dut_nodedup (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_client(req_client),
    .req_amount(req_amount), .req_ready(req_ready0), .out_valid(out_valid0),
    .out_client(out_client0), .out_amount(out_amount0), .out_ready(out_ready),
    .drop_cnt(drop_cnt0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: expected issued cancels {client,amount} awaiting acceptance.
  logic [20:0] exp_q[$];
  bit          m_valid = 0;
  int          m_ptr   = 0;
  bit          m_lvalid = 0;
  int          m_lc = 0, m_la = 0;
  int          m_drop = 0;

  logic [4:0]  s_cl[4];
  logic [15:0] s_am[4];

  // Evaluated mid-cycle after inputs settle; predicts the coming clock edge.
  task automatic model_step();
    logic [3:0] exp_ready;
    int g, idx, c, a;
    exp_ready = '0;
    if (rst) begin
      exp_q.delete();
      m_valid = 0; m_ptr = 0; m_lvalid = 0; m_drop = 0;
    end else if (!m_valid || out_ready) begin
      g = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        m_ptr = (g + 1) % 4;
        c = int'(s_cl[g]);
        a = int'(s_am[g]);
        if (m_lvalid && c == m_lc && a == m_la) begin
          if (m_drop < 255) m_drop++;
          m_valid = 0;
        end else begin
          exp_q.push_back({s_cl[g], s_am[g]});
          m_valid = 1;
          m_lvalid = 1; m_lc = c; m_la = a;
        end
      end else begin
        m_valid = 0;
      end
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic ordy);
    @(posedge clk);
    #1;
    rst = r;
    req_valid = v;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) begin
      req_client[i*5 +: 5]   = s_cl[i];
      req_amount[i*16 +: 16] = s_am[i];
    end
    #5;
    model_step();
  endtask

  // Monitor: compares the presented slot against the scoreboard each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0)
        check("out_data", 32'({out_client, out_amount}), 32'(exp_q[0]));
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("drop_cnt_nodedup", 32'(drop_cnt0), 32'd0);
    end
  end

  task automatic set_all(input int base);
    for (int i = 0; i < 4; i++) begin
      s_cl[i] = 5'(i + 10);
      s_am[i] = 16'(base + i);
    end
  endtask

  initial begin
    set_all(0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 1'b0);

    // Single request after reset.
    s_cl[0] = 5'd3; s_am[0] = 16'd100;
    step(1'b0, 4'b0001, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // All requesters busy with full throughput.
    for (int c = 0; c < 10; c++) begin
      set_all(1000 + c * 8);
      step(1'b0, 4'b1111, 1'b1);
    end
    step(1'b0, 4'b0000, 1'b1);

    // Stall: slot held with (7,50) while requester 1 waits.
    s_cl[0] = 5'd7; s_am[0] = 16'd50;
    step(1'b0, 4'b0001, 1'b1);
    s_cl[1] = 5'd2; s_am[1] = 16'd60;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // Duplicate suppression.
    s_cl[0] = 5'd9; s_am[0] = 16'd500;
    step(1'b0, 4'b0001, 1'b1);
    step(1'b0, 4'b0001, 1'b1);
    s_am[0] = 16'd501;
    step(1'b0, 4'b0001, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // Saturation of the drop counter.
    s_cl[0] = 5'd1; s_am[0] = 16'd1;
    for (int i = 0; i < 300; i++) step(1'b0, 4'b0001, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    #4;
    check("drop_saturated", 32'(drop_cnt), 32'd255);

    // Reset during a stalled output, then pointer restarts at 0.
    s_cl[0] = 5'd4; s_am[0] = 16'd44;
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    s_cl[0] = 5'd1; s_am[0] = 16'd1;
    s_cl[3] = 5'd8; s_am[3] = 16'd8;
    step(1'b0, 4'b1001, 1'b1);
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // Randomized traffic with a narrow value space to provoke duplicates.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        s_cl[i] = 5'($urandom_range(0, 2));
        s_am[i] = 16'($urandom_range(0, 2));
      end
      step(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 7));
    end
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
